// File: rtl/cve2_irq_arbiter.sv
// Interrupt arbiter: edge-latched NMI plus 19 level sources, fixed priority,
// a request/acknowledge handshake and a hold-off window after each acknowledge.
package cve2_irq_pkg;

   typedef struct packed {
      logic        irq_software;
      logic        irq_timer;
      logic        irq_external;
      logic [15:0] irq_fast;
   } irqs_t;

   typedef enum logic [6:0] {
      EXC_CAUSE_NONE            = 7'h00,
      EXC_CAUSE_IRQ_SOFTWARE_M  = 7'h43,
      EXC_CAUSE_IRQ_TIMER_M     = 7'h47,
      EXC_CAUSE_IRQ_EXTERNAL_M  = 7'h4B,
      EXC_CAUSE_IRQ_FAST_0      = 7'h50,
      EXC_CAUSE_IRQ_FAST_1      = 7'h51,
      EXC_CAUSE_IRQ_FAST_2      = 7'h52,
      EXC_CAUSE_IRQ_FAST_3      = 7'h53,
      EXC_CAUSE_IRQ_FAST_4      = 7'h54,
      EXC_CAUSE_IRQ_FAST_5      = 7'h55,
      EXC_CAUSE_IRQ_FAST_6      = 7'h56,
      EXC_CAUSE_IRQ_FAST_7      = 7'h57,
      EXC_CAUSE_IRQ_FAST_8      = 7'h58,
      EXC_CAUSE_IRQ_FAST_9      = 7'h59,
      EXC_CAUSE_IRQ_FAST_10     = 7'h5A,
      EXC_CAUSE_IRQ_FAST_11     = 7'h5B,
      EXC_CAUSE_IRQ_FAST_12     = 7'h5C,
      EXC_CAUSE_IRQ_FAST_13     = 7'h5D,
      EXC_CAUSE_IRQ_FAST_14     = 7'h5E,
      EXC_CAUSE_IRQ_FAST_15     = 7'h5F,
      EXC_CAUSE_IRQ_NM          = 7'h60
   } exc_cause_e;

endpackage

module cve2_irq_arbiter
   import cve2_irq_pkg::*;
#(
   parameter int unsigned AckBlockCycles = 32'd2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  irqs_t      irqs_i,
   input  logic       irq_nm_i,
   input  irqs_t      irq_en_i,
   input  logic       mstatus_mie_i,
   input  logic       debug_mode_i,
   input  logic       nmi_mode_i,
   input  logic       irq_ack_i,
   output logic       irq_req_o,
   output exc_cause_e irq_cause_o,
   output logic       irq_nm_pending_o,
   output logic       irq_pending_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      BLOCK = 2'd2
   } state_e;

   localparam logic [2:0] BlockLoad = 3'(AckBlockCycles - 32'd1);

   // Highest-priority eligible cause; later assignments override earlier ones.
   function automatic exc_cause_e prio_cause(input irqs_t elig, input logic nm);
      exc_cause_e res;
      res = EXC_CAUSE_NONE;
      if (elig.irq_timer) res = EXC_CAUSE_IRQ_TIMER_M;
      else                res = res;
      if (elig.irq_software) res = EXC_CAUSE_IRQ_SOFTWARE_M;
      else                   res = res;
      if (elig.irq_external) res = EXC_CAUSE_IRQ_EXTERNAL_M;
      else                   res = res;
      for (int i = 15; i >= 0; i--) begin
         if (elig.irq_fast[i]) res = exc_cause_e'({1'b1, 6'(i) + 6'd16});
         else                  res = res;
      end
      if (nm) res = EXC_CAUSE_IRQ_NM;
      else    res = res;
      return res;
   endfunction

   function automatic logic src_eligible(input exc_cause_e cause, input irqs_t elig,
                                         input logic nm);
      logic res;
      case (cause)
         EXC_CAUSE_IRQ_NM:         res = nm;
         EXC_CAUSE_IRQ_EXTERNAL_M: res = elig.irq_external;
         EXC_CAUSE_IRQ_SOFTWARE_M: res = elig.irq_software;
         EXC_CAUSE_IRQ_TIMER_M:    res = elig.irq_timer;
         default: begin
            if (cause[6:4] == 3'b101) res = elig.irq_fast[cause[3:0]];
            else                      res = 1'b0;
         end
      endcase
      return res;
   endfunction

   state_e     state_r;
   logic       irq_req_r;
   exc_cause_e cause_r;
   logic [2:0] cnt_r;
   logic       nm_prev_r;
   logic       nm_latch_r;

   logic        nm_edge_s;
   logic        nm_elig_s;
   logic        mask_ok_s;
   logic [18:0] elig_vec_s;
   irqs_t       elig_src_s;
   logic        any_elig_s;
   exc_cause_e  best_cause_s;
   logic        cap_elig_s;
   logic        nm_ack_s;

   // Eligibility and arbitration; an NMI edge counts in the cycle it arrives.
   always_comb begin
      nm_edge_s    = irq_nm_i & ~nm_prev_r;
      nm_elig_s    = (nm_latch_r | nm_edge_s) & ~debug_mode_i & ~nmi_mode_i;
      mask_ok_s    = mstatus_mie_i & ~debug_mode_i & ~nmi_mode_i;
      elig_vec_s   = irqs_i & irq_en_i & {19{mask_ok_s}};
      elig_src_s   = irqs_t'(elig_vec_s);
      any_elig_s   = (|elig_vec_s) | nm_elig_s;
      best_cause_s = prio_cause(elig_src_s, nm_elig_s);
      cap_elig_s   = src_eligible(cause_r, elig_src_s, nm_elig_s);
      nm_ack_s     = (state_r == REQ) & irq_ack_i & (cause_r == EXC_CAUSE_IRQ_NM);
   end

   // NMI edge detector and latch; a new edge beats a simultaneous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         nm_prev_r  <= 1'b0;
         nm_latch_r <= 1'b0;
      end else begin
         nm_prev_r <= irq_nm_i;
         if (nm_edge_s)     nm_latch_r <= 1'b1;
         else if (nm_ack_s) nm_latch_r <= 1'b0;
         else               nm_latch_r <= nm_latch_r;
      end
   end

   // Request FSM; leaving BLOCK re-arbitrates directly so the hold-off is exact.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         irq_req_r <= 1'b0;
         cause_r   <= EXC_CAUSE_NONE;
         cnt_r     <= 3'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_elig_s) begin
                  state_r   <= REQ;
                  irq_req_r <= 1'b1;
                  cause_r   <= best_cause_s;
               end else begin
                  irq_req_r <= 1'b0;
               end
            end
            REQ: begin
               if (irq_ack_i) begin
                  state_r   <= BLOCK;
                  irq_req_r <= 1'b0;
                  cnt_r     <= BlockLoad;
               end else if (nm_elig_s && (cause_r != EXC_CAUSE_IRQ_NM)) begin
                  irq_req_r <= 1'b1;
                  cause_r   <= EXC_CAUSE_IRQ_NM;
               end else if (!cap_elig_s) begin
                  state_r   <= IDLE;
                  irq_req_r <= 1'b0;
               end else begin
                  irq_req_r <= 1'b1;
               end
            end
            BLOCK: begin
               if (cnt_r != 3'd0) begin
                  cnt_r     <= cnt_r - 3'd1;
                  irq_req_r <= 1'b0;
               end else if (any_elig_s) begin
                  state_r   <= REQ;
                  irq_req_r <= 1'b1;
                  cause_r   <= best_cause_s;
               end else begin
                  state_r   <= IDLE;
                  irq_req_r <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               irq_req_r <= 1'b0;
            end
         endcase
      end
   end

   assign irq_req_o        = irq_req_r;
   assign irq_cause_o      = cause_r;
   assign irq_nm_pending_o = nm_latch_r;
   assign irq_pending_o    = (|(irqs_i & irq_en_i)) | nm_latch_r;

endmodule

// File: tb/tb_cve2_irq_arbiter.sv
// Bench for cve2_irq_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_cve2_irq_arbiter;

   localparam int N = 2;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [18:0] irqs_i, irq_en_i;
   logic        irq_nm_i, mstatus_mie_i, debug_mode_i, nmi_mode_i, irq_ack_i;
   logic        irq_req_o, irq_nm_pending_o, irq_pending_o;
   logic [6:0]  irq_cause_o;
   logic        req1, nmp1, pend1;
   logic [6:0]  cause1;

   always #5 clk = ~clk;

   cve2_irq_arbiter #(.AckBlockCycles(N)) dut (
      .clk_i(clk), .rst_i(rst_i), .irqs_i(irqs_i), .irq_nm_i(irq_nm_i),
      .irq_en_i(irq_en_i), .mstatus_mie_i(mstatus_mie_i), .debug_mode_i(debug_mode_i),
      .nmi_mode_i(nmi_mode_i), .irq_ack_i(irq_ack_i), .irq_req_o(irq_req_o),
      .irq_cause_o(irq_cause_o), .irq_nm_pending_o(irq_nm_pending_o),
      .irq_pending_o(irq_pending_o));

   cve2_irq_arbiter #(.AckBlockCycles(1)) dut1 (
      .clk_i(clk), .rst_i(rst_i), .irqs_i(irqs_i), .irq_nm_i(irq_nm_i),
      .irq_en_i(irq_en_i), .mstatus_mie_i(mstatus_mie_i), .debug_mode_i(debug_mode_i),
      .nmi_mode_i(nmi_mode_i), .irq_ack_i(irq_ack_i), .irq_req_o(req1),
      .irq_cause_o(cause1), .irq_nm_pending_o(nmp1), .irq_pending_o(pend1));

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: request visible, presented cause, suppressed arbitration edges, NMI latch
   bit         m_req;
   logic [6:0] m_cause;
   int         m_low;
   bit         m_nmi, m_prev;

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Priority rank k (0 = highest maskable) -> irqs bit / cause code
   function automatic int bit_of(input int k);
      if (k < 16) return k;
      else if (k == 16) return 16;
      else if (k == 17) return 18;
      else return 17;
   endfunction

   function automatic logic [6:0] cause_of(input int k);
      if (k < 16) return 7'h50 + 7'(k);
      else if (k == 16) return 7'h4B;
      else if (k == 17) return 7'h43;
      else return 7'h47;
   endfunction

   function automatic logic [6:0] model_best(input logic [18:0] el, input bit nm);
      if (nm) return 7'h60;
      for (int k = 0; k < 19; k++) if (el[bit_of(k)]) return cause_of(k);
      return 7'h00;
   endfunction

   function automatic bit model_src(input logic [6:0] c, input logic [18:0] el, input bit nm);
      if (c == 7'h60) return nm;
      for (int k = 0; k < 19; k++) if (cause_of(k) == c) return el[bit_of(k)];
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_req = 0; m_cause = 7'h00; m_low = 0; m_nmi = 0; m_prev = 0;
   endtask

   task automatic model_step();
      bit nm_edge, nmi_el, new_nmi;
      logic [18:0] el;
      if (rst_i) begin
         model_reset();
      end else begin
         nm_edge = irq_nm_i && !m_prev;
         nmi_el  = (m_nmi || nm_edge) && !debug_mode_i && !nmi_mode_i;
         el      = (mstatus_mie_i && !debug_mode_i && !nmi_mode_i) ? (irqs_i & irq_en_i) : 19'd0;
         new_nmi = nm_edge ? 1'b1 : ((m_req && irq_ack_i && m_cause == 7'h60) ? 1'b0 : m_nmi);
         if (m_req) begin
            if (irq_ack_i) begin
               m_req = 0;
               m_low = N - 1;
            end else if (nmi_el && m_cause != 7'h60) begin
               m_cause = 7'h60;
            end else if (!model_src(m_cause, el, nmi_el)) begin
               m_req = 0;
            end
         end else if (m_low > 0) begin
            m_low--;
         end else if (nmi_el || el != 19'd0) begin
            m_req   = 1;
            m_cause = model_best(el, nmi_el);
         end
         m_nmi  = new_nmi;
         m_prev = irq_nm_i;
      end
   endtask

   task automatic check();
      chk("req", 7'(irq_req_o), 7'(m_req));
      chk("cause", irq_cause_o, m_cause);
      chk("nm_pending", 7'(irq_nm_pending_o), 7'(m_nmi));
      chk("pending", 7'(irq_pending_o), 7'((|(irqs_i & irq_en_i)) | m_nmi));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check();
   endtask

   initial begin
      rst_i = 1; irqs_i = '0; irq_en_i = '1; irq_nm_i = 0; mstatus_mie_i = 1;
      debug_mode_i = 0; nmi_mode_i = 0; irq_ack_i = 0;
      model_reset();
      cyc();
      chk("rst_req", 7'(irq_req_o), 7'd0);
      chk("rst_cause", irq_cause_o, 7'h00);
      chk("rst_nmp", 7'(irq_nm_pending_o), 7'd0);

      rst_i = 0; irqs_i = 19'h20000;                 // timer
      cyc();
      chk("timer_req", 7'(irq_req_o), 7'd1);
      chk("timer_cause", irq_cause_o, 7'h47);
      chk("n1_req", 7'(req1), 7'd1);
      irq_ack_i = 1; cyc();
      chk("block1", 7'(irq_req_o), 7'd0);
      chk("n1_block", 7'(req1), 7'd0);
      irq_ack_i = 0; cyc();
      chk("block2", 7'(irq_req_o), 7'd0);
      chk("n1_rearm", 7'(req1), 7'd1);
      cyc();
      chk("timer_again", 7'(irq_req_o), 7'd1);
      chk("timer_again_cause", irq_cause_o, 7'h47);

      irq_ack_i = 1; irqs_i = 19'h30008;             // fast[3] + external + timer
      cyc(); irq_ack_i = 0; cyc(); cyc();
      chk("prio_req", 7'(irq_req_o), 7'd1);
      chk("prio_cause", irq_cause_o, 7'h53);
      irq_ack_i = 1; irqs_i = 19'h30000;
      cyc(); irq_ack_i = 0; cyc(); cyc();
      chk("ext_cause", irq_cause_o, 7'h4B);

      irq_ack_i = 1; irqs_i = 19'h20000;
      cyc(); irq_ack_i = 0; cyc(); cyc();
      chk("pre_nmi_cause", irq_cause_o, 7'h47);
      irq_nm_i = 1; cyc();
      chk("nmi_cause", irq_cause_o, 7'h60);
      chk("nmi_req", 7'(irq_req_o), 7'd1);
      chk("nmi_pend", 7'(irq_nm_pending_o), 7'd1);
      irq_ack_i = 1; cyc();                           // irq_nm_i held high: no re-latch
      chk("nmi_clr", 7'(irq_nm_pending_o), 7'd0);
      irq_ack_i = 0; irq_nm_i = 0; cyc(); cyc();
      chk("timer_back", irq_cause_o, 7'h47);

      mstatus_mie_i = 0; cyc();
      chk("mie_drop_req", 7'(irq_req_o), 7'd0);
      chk("wfi_pend", 7'(irq_pending_o), 7'd1);
      mstatus_mie_i = 1; debug_mode_i = 1; cyc();
      irq_nm_i = 1; cyc();
      chk("dbg_nmp", 7'(irq_nm_pending_o), 7'd1);
      chk("dbg_req", 7'(irq_req_o), 7'd0);
      debug_mode_i = 0; irq_nm_i = 0; cyc();
      chk("dbg_exit_req", 7'(irq_req_o), 7'd1);
      chk("dbg_exit_cause", irq_cause_o, 7'h60);

      rst_i = 1; irq_nm_i = 1; #1;
      model_reset(); check();
      chk("async_req", 7'(irq_req_o), 7'd0);
      chk("async_cause", irq_cause_o, 7'h00);
      chk("async_nmp", 7'(irq_nm_pending_o), 7'd0);
      cyc();
      rst_i = 0; cyc();
      chk("rel_nmi", 7'(irq_nm_pending_o), 7'd1);
      chk("rel_cause", irq_cause_o, 7'h60);
      irq_ack_i = 1; irq_nm_i = 0; irqs_i = '0;
      cyc(); irq_ack_i = 0; cyc(); cyc();

      for (int c = 0; c < 4000; c++) begin
         rst_i         = ($urandom_range(0, 199) == 0);
         irqs_i        = 19'($urandom) & 19'($urandom) & 19'($urandom);
         irq_en_i      = ($urandom_range(0, 9) == 0) ? 19'($urandom) : 19'h7FFFF;
         mstatus_mie_i = ($urandom_range(0, 9) != 0);
         debug_mode_i  = ($urandom_range(0, 19) == 0);
         nmi_mode_i    = ($urandom_range(0, 19) == 0);
         irq_ack_i     = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 14) == 0) irq_nm_i = ~irq_nm_i;
         if (rst_i) begin
            #1;
            model_reset();
            check();
         end
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
